// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one request per three cycles through an external ALU and returns a registered response
module alu_sequencer #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [SIZE-1:0] req_a,
  input  logic [SIZE-1:0] req_b,
  output logic [3:0]      alu_funct,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  input  logic [SIZE-1:0] alu_result,
  input  logic            alu_overflow,
  input  logic            alu_equal,
  input  logic            alu_less,
  input  logic            alu_greater,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SIZE-1:0] rsp_data,
  output logic            rsp_taken,
  output logic            rsp_overflow,
  output logic            rsp_illegal
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int SH = $clog2(SIZE);
  logic [1:0] state;
  logic [3:0] op_q;
  logic [3:0] funct;
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;
  logic exec;
  logic illegal;
  logic shift;
  logic zero_b;
  logic taken;
  always_comb begin
    funct = 4'b1111;
    case (op_q)
      4'd0: funct = 4'b0000;
      4'd1: funct = 4'b0001;
      4'd2: funct = 4'b0010;
      4'd3: funct = 4'b0011;
      4'd4: funct = 4'b0101;
      4'd5: funct = 4'b0111;
      4'd6: funct = 4'b1000;
      4'd7: funct = 4'b1001;
      4'd8: funct = 4'b1010;
      4'd9: funct = 4'b0110;
      4'd10, 4'd11, 4'd12, 4'd13: funct = 4'b0001;
      default: funct = 4'b1111;
    endcase
  end
  assign exec = state == EXEC;
  assign illegal = op_q[3:1] == 3'b111;
  assign shift = op_q inside {4'd2, 4'd3, 4'd4};
  assign zero_b = op_q == 4'd7 || op_q == 4'd9;
  assign taken = op_q == 4'd10 ? alu_equal :
                 op_q == 4'd11 ? !alu_equal :
                 op_q == 4'd12 ? alu_less :
                 op_q == 4'd13 ? alu_greater : 1'b0;
  assign alu_funct = exec ? funct : 4'b1111;
  assign alu_a = exec && !illegal ? a_q : '0;
  assign alu_b = !exec || illegal || zero_b ? '0 :
                 shift ? {{(SIZE-SH){1'b0}}, b_q[SH-1:0]} : b_q;
  assign req_ready = rst_n && state == IDLE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_data <= '0;
      rsp_taken <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (req_valid && req_ready) begin
      state <= EXEC;
      op_q <= req_op;
      a_q <= req_a;
      b_q <= req_b;
    end else if (exec) begin
      state <= RESP;
      rsp_data <= illegal ? '0 : alu_result;
      rsp_taken <= taken;
      rsp_overflow <= op_q <= 4'd1 && alu_overflow;
      rsp_illegal <= illegal;
    end else if (rsp_valid && rsp_ready) begin
      state <= IDLE;
    end
  end
endmodule
